// File: rtl/serial_add_ctrl_pkg.sv
// Shared constants for the nibble-serial add/subtract controller:
// FSM state encoding, adder slice width and the index width helper.
package serial_add_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Nibble index width; a single-nibble operand still needs a 1-bit index.
    function automatic int idx_bits(input int nibbles);
        return (nibbles <= 1) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a requesting datapath (master) and the
// nibble-serial add/subtract controller (slave).
interface serial_add_ctrl_if #(
    parameter int NIBBLES = 4
);
    import serial_add_ctrl_pkg::*;

    localparam int W = NIBBLE_W * NIBBLES;

    // Handshake: start is a request level, accepted at any rising edge where the
    // controller is idle (busy=0, done=0); a, b, op and carryin are captured at that
    // edge only. done is a single-cycle result-valid strobe with no back-pressure;
    // sum/carryout/overflow hold their values until the next done.
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carryin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carryout;
    logic         overflow;

    modport master (
        output start, op, a, b, carryin,
        input  busy, done, sum, carryout, overflow
    );

    modport slave (
        input  start, op, a, b, carryin,
        output busy, done, sum, carryout, overflow
    );

endinterface

// File: rtl/serial_add_ctrl_rca.sv
// Shared 4-bit ripple-carry adder slice used one nibble per clock by the
// serial add/subtract controller.
module rippleCarryAdder
    import serial_add_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                carryin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                carryout
);

    logic [NIBBLE_W:0] c;

    assign c[0] = carryin;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign carryout = c[NIBBLE_W];

endmodule

// File: rtl/serial_add_ctrl.sv
// Wide add/subtract by time-multiplexing one 4-bit ripple adder, LS nibble first.
// Owns operand capture, the inter-nibble carry, result assembly and overflow.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    serial_add_ctrl_if.slave     bus,
    output logic [1:0]           state_o
);

    localparam int IW = idx_bits(NIBBLES);

    typedef logic [NIBBLES-1:0][NIBBLE_W-1:0] word_t;

    logic [1:0]          state_q, state_d;
    word_t               a_q, a_d;
    word_t               b_q, b_d;
    word_t               sum_q, sum_d;
    logic                c_q, c_d;
    logic                co_q, co_d;
    logic                ov_q, ov_d;
    logic [IW-1:0]       idx_q, idx_d;

    logic [NIBBLE_W-1:0] a_nib, b_nib, add_sum;
    logic                add_co;
    logic                last_nib;

    assign last_nib = (idx_q == IW'(NIBBLES - 1));

    // Operand nibble select written as a compare-mux so every NIBBLES value
    // (including non powers of two) indexes only legal nibbles.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IW'(i)) begin
                a_nib = a_q[i];
                b_nib = b_q[i];
            end
        end
    end

    rippleCarryAdder u_rca (
        .a        (a_nib),
        .b        (b_nib),
        .carryin  (c_q),
        .sum      (add_sum),
        .carryout (add_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_d     = c_q;
        co_d    = co_q;
        ov_d    = ov_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    // Subtract is a + ~b + 1, so B is stored inverted and C preset.
                    a_d     = bus.a;
                    b_d     = bus.op ? ~bus.b : bus.b;
                    c_d     = bus.op ? 1'b1 : bus.carryin;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IW'(i)) sum_d[i] = add_sum;
                end
                c_d = add_co;
                if (last_nib) begin
                    // Flags are latched with the top nibble so they are valid during done.
                    co_d    = add_co;
                    ov_d    = (a_q[NIBBLES-1][NIBBLE_W-1] == b_q[NIBBLES-1][NIBBLE_W-1]) &&
                              (add_sum[NIBBLE_W-1] != a_q[NIBBLES-1][NIBBLE_W-1]);
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.busy     = (state_q == ST_RUN);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.sum      = sum_q;
    assign bus.carryout = co_q;
    assign bus.overflow = ov_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: a 4-nibble and a 1-nibble instance checked against
// a signed/unsigned arithmetic reference model.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rstn4, rstn1;
    logic [1:0] st4, st1;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    serial_add_ctrl_if #(.NIBBLES(4)) bus4 ();
    serial_add_ctrl_if #(.NIBBLES(1)) bus1 ();

    serial_add_ctrl #(.NIBBLES(4)) dut4 (
        .clk(clk), .resetn(rstn4), .bus(bus4.slave), .state_o(st4)
    );
    serial_add_ctrl #(.NIBBLES(1)) dut1 (
        .clk(clk), .resetn(rstn1), .bus(bus1.slave), .state_o(st1)
    );

    // Reference: {overflow, carryout, sum} from integer arithmetic on w-bit operands.
    function automatic logic [17:0] model(input int w, input logic op, input logic cin,
                                          input logic [15:0] a, input logic [15:0] b);
        longint mask, lim, ua, ub, sa, sb, ures, sres;
        logic   co, ov;
        mask = (longint'(1) << w) - 1;
        lim  = longint'(1) << (w - 1);
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        sa   = (ua >= lim) ? ua - (mask + 1) : ua;
        sb   = (ub >= lim) ? ub - (mask + 1) : ub;
        if (op) begin
            ures = ua - ub;
            co   = (ua >= ub);
            sres = sa - sb;
        end else begin
            ures = ua + ub + longint'(cin);
            co   = (ures > mask);
            sres = sa + sb + longint'(cin);
        end
        ov = (sres >= lim) || (sres < -lim);
        return {ov, co, 16'(ures & mask)};
    endfunction

    task automatic drive(input int nib, input logic st, input logic op, input logic cin,
                         input logic [15:0] a, input logic [15:0] b);
        if (nib == 4) begin
            bus4.start = st; bus4.op = op; bus4.carryin = cin; bus4.a = a; bus4.b = b;
        end else begin
            bus1.start = st; bus1.op = op; bus1.carryin = cin; bus1.a = a[3:0]; bus1.b = b[3:0];
        end
    endtask

    task automatic sample(input int nib, output logic busy, output logic done,
                          output logic [15:0] sum, output logic co, output logic ov,
                          output logic [1:0] st);
        if (nib == 4) begin
            busy = bus4.busy; done = bus4.done; sum = bus4.sum;
            co = bus4.carryout; ov = bus4.overflow; st = st4;
        end else begin
            busy = bus1.busy; done = bus1.done; sum = {12'h000, bus1.sum};
            co = bus1.carryout; ov = bus1.overflow; st = st1;
        end
    endtask

    task automatic drive_random(input int nib, input logic st);
        drive(nib, st, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              16'($urandom), 16'($urandom));
    endtask

    // One operation; inputs are scrambled after capture, and with poke the start
    // line is re-asserted throughout RUN and DONE.
    task automatic run_op(input int nib, input logic op, input logic cin,
                          input logic [15:0] a, input logic [15:0] b,
                          input bit poke, input string tag);
        logic [17:0] exp;
        logic [15:0] m, sum, r_sum;
        logic        busy, done, co, ov, r_co, r_ov;
        logic [1:0]  st;
        int          done_cnt, done_at, bad_busy;
        m        = (nib == 4) ? 16'hFFFF : 16'h000F;
        exp      = model(nib * 4, op, cin, a & m, b & m);
        done_cnt = 0;
        done_at  = -1;
        bad_busy = 0;
        r_sum    = '0;
        r_co     = 1'b0;
        r_ov     = 1'b0;
        @(negedge clk);
        drive(nib, 1'b1, op, cin, a, b);
        @(posedge clk);
        #1;
        drive_random(nib, poke);
        for (int k = 1; k <= 2 * nib + 3; k++) begin
            @(posedge clk);
            #1;
            sample(nib, busy, done, sum, co, ov, st);
            if (done === 1'b1) begin
                done_cnt++;
                done_at = k;
                r_sum   = sum;
                r_co    = co;
                r_ov    = ov;
            end
            if (busy !== ((k < nib) ? 1'b1 : 1'b0)) bad_busy++;
            drive_random(nib, poke && (k <= nib));
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++; $display("FAIL %s done_count got %0d exp 1", tag, done_cnt);
        end
        checks++;
        if (done_at !== nib) begin
            errors++; $display("FAIL %s done_cycle got %0d exp %0d", tag, done_at, nib);
        end
        checks++;
        if (bad_busy !== 0) begin
            errors++; $display("FAIL %s busy_profile bad_cycles %0d exp 0", tag, bad_busy);
        end
        checks++;
        if (r_sum !== exp[15:0]) begin
            errors++; $display("FAIL %s sum got %h exp %h", tag, r_sum, exp[15:0]);
        end
        checks++;
        if (r_co !== exp[16]) begin
            errors++; $display("FAIL %s carryout got %b exp %b", tag, r_co, exp[16]);
        end
        checks++;
        if (r_ov !== exp[17]) begin
            errors++; $display("FAIL %s overflow got %b exp %b", tag, r_ov, exp[17]);
        end
        checks++;
        if ({ov, co, sum} !== exp) begin
            errors++; $display("FAIL %s hold got %h exp %h", tag, {ov, co, sum}, exp);
        end
        checks++;
        if (st !== 2'd0) begin
            errors++; $display("FAIL %s final_state got %0d exp 0", tag, st);
        end
    endtask

    task automatic test_reset();
        logic [15:0] sum;
        logic        busy, done, co, ov;
        logic [1:0]  st;
        int          act;
        drive(4, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        rstn4 = 1'b0;
        rstn1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn4 = 1'b1;
        rstn1 = 1'b1;
        sample(4, busy, done, sum, co, ov, st);
        checks++;
        if ({busy, done, co, ov, st, sum} !== 22'd0) begin
            errors++; $display("FAIL reset_n4 outputs got %h exp 0", {busy, done, co, ov, st, sum});
        end
        sample(1, busy, done, sum, co, ov, st);
        checks++;
        if ({busy, done, co, ov, st, sum} !== 22'd0) begin
            errors++; $display("FAIL reset_n1 outputs got %h exp 0", {busy, done, co, ov, st, sum});
        end
        // start together with reset: the request must be dropped
        @(negedge clk);
        drive(4, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h4321);
        rstn4 = 1'b0;
        @(posedge clk);
        #1;
        rstn4 = 1'b1;
        drive(4, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        act = 0;
        for (int k = 0; k < 8; k++) begin
            sample(4, busy, done, sum, co, ov, st);
            if (busy === 1'b1 || done === 1'b1 || st !== 2'd0) act++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (act !== 0) begin
            errors++; $display("FAIL reset_with_start active_cycles got %0d exp 0", act);
        end
    endtask

    task automatic test_directed();
        run_op(4, 1'b0, 1'b0, 16'h1234, 16'h4321, 1'b0, "add_1234_4321");
        run_op(4, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 1'b0, "add_ripple");
        run_op(4, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 1'b0, "add_overflow");
        run_op(4, 1'b1, 1'b0, 16'h0005, 16'h0007, 1'b0, "sub_borrow");
        run_op(4, 1'b1, 1'b1, 16'h8000, 16'h0001, 1'b0, "sub_overflow");
        run_op(4, 1'b0, 1'b1, 16'h0FFF, 16'hF000, 1'b0, "add_carryin");
        run_op(4, 1'b0, 1'b0, 16'h1234, 16'h4321, 1'b1, "start_ignored");
    endtask

    task automatic test_abort();
        logic [15:0] sum;
        logic        busy, done, co, ov;
        logic [1:0]  st;
        int          dones;
        @(negedge clk);
        drive(4, 1'b1, 1'b0, 1'b0, 16'h1111, 16'h2222);
        @(posedge clk);
        #1;
        drive(4, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        rstn4 = 1'b0;
        @(posedge clk);
        #1;
        rstn4 = 1'b1;
        sample(4, busy, done, sum, co, ov, st);
        checks++;
        if ({busy, done, co, ov, st, sum} !== 22'd0) begin
            errors++; $display("FAIL abort_outputs got %h exp 0", {busy, done, co, ov, st, sum});
        end
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            sample(4, busy, done, sum, co, ov, st);
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++; $display("FAIL abort_no_done active_cycles got %0d exp 0", dones);
        end
        run_op(4, 1'b0, 1'b0, 16'h0001, 16'h0001, 1'b0, "after_abort");
    endtask

    task automatic test_back_to_back();
        logic [17:0] exp;
        logic [15:0] a, b, sum;
        logic        op, cin, busy, done, co, ov;
        logic [1:0]  st;
        int          bad_pat, bad_res, dones;
        a   = 16'($urandom);
        b   = 16'($urandom);
        op  = 1'($urandom_range(0, 1));
        cin = 1'($urandom_range(0, 1));
        exp = model(16, op, cin, a, b);
        bad_pat = 0;
        bad_res = 0;
        dones   = 0;
        @(negedge clk);
        drive(4, 1'b1, op, cin, a, b);
        for (int k = 0; k <= 17; k++) begin
            @(posedge clk);
            #1;
            if (k >= 1) begin
                sample(4, busy, done, sum, co, ov, st);
                if (done !== ((k >= 4 && (k - 4) % 6 == 0) ? 1'b1 : 1'b0)) bad_pat++;
                if (busy === 1'b1 && done === 1'b1) bad_pat++;
                if (done === 1'b1) begin
                    dones++;
                    if ({ov, co, sum} !== exp) bad_res++;
                end
            end
        end
        drive(4, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (4) @(posedge clk);
        checks++;
        if (dones !== 3) begin
            errors++; $display("FAIL b2b done_count got %0d exp 3", dones);
        end
        checks++;
        if (bad_pat !== 0) begin
            errors++; $display("FAIL b2b done_spacing bad_cycles %0d exp 0", bad_pat);
        end
        checks++;
        if (bad_res !== 0) begin
            errors++; $display("FAIL b2b result bad_results %0d exp 0", bad_res);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_op(4, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), "random_n4");
        end
    endtask

    task automatic test_sweep_n1();
        for (int op = 0; op < 2; op++) begin
            for (int cin = 0; cin < 2; cin++) begin
                for (int a = 0; a < 16; a++) begin
                    for (int b = 0; b < 16; b++) begin
                        run_op(1, 1'(op), 1'(cin), 16'(a), 16'(b), 1'b0, "sweep_n1");
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_abort();
        test_back_to_back();
        test_random();
        test_sweep_n1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
